// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: round-robin digit scan with dead time,
// nibble decode, leading-zero blanking and tear-free frame-boundary updates.
module seven_segment_scanner #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic                  hex_en,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  upd_done
);

  localparam int   CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp, r_pend;
  logic [DIGITS-1:0]   r_disp_dp, r_pend_dp;
  logic                r_pending;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_upd;

  logic                w_slot_end, w_frame_end, w_dead, w_nz, w_blank, w_dpsel;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_hot;

  function automatic logic [6:0] f_decode(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    if (n > 4'd9 && !hex) s = '0;
    return s;
  endfunction

  assign w_slot_end  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
  assign w_dead      = int'(r_cnt) < DEAD_CYCLES;
  assign w_hot       = DIGITS'(1) << r_idx;

  // w_nz: any nonzero nibble at or above the scanned digit, so the digit is a leading zero otherwise
  always_comb begin
    w_nib   = '0;
    w_dpsel = 1'b0;
    w_nz    = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k == 32'(r_idx)) begin
        w_nib   = r_disp[4*k +: 4];
        w_dpsel = r_disp_dp[k];
      end
      if (k >= 32'(r_idx) && r_disp[4*k +: 4] != 4'd0) w_nz = 1'b1;
    end
    w_blank = lz_blank && (r_idx != '0) && !w_nz;
    w_seg   = w_blank ? '0 : f_decode(w_nib, hex_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load landing on the frame boundary bypasses pend and goes straight to disp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp    <= '0;
      r_disp_dp <= '0;
      r_pend    <= '0;
      r_pend_dp <= '0;
      r_pending <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_frame_end) begin
        if (load) begin
          r_disp    <= value;
          r_disp_dp <= dp_mask;
        end else if (r_pending) begin
          r_disp    <= r_pend;
          r_disp_dp <= r_pend_dp;
        end
        r_pending <= 1'b0;
        r_upd     <= load | r_pending;
      end else if (load) begin
        r_pend    <= value;
        r_pend_dp <= dp_mask;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= {DIGITS{AN_INV}};
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
    end else if (w_dead) begin
      r_an  <= {DIGITS{AN_INV}};
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
    end else begin
      r_an  <= w_hot ^ {DIGITS{AN_INV}};
      r_seg <= w_seg ^ {7{SEG_INV}};
      r_dp  <= w_dpsel ^ SEG_INV;
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign upd_done = r_upd;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: arithmetic scan model checked every cycle,
// a vector table of displayed values, and hand sequences for boundary/reset cases.
module tb_seven_segment_scanner;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int DC = 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        load = 1'b0, hex_en = 1'b0, lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        upd_done;

  seven_segment_scanner #(
    .DIGITS(D), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask), .load(load),
    .hex_en(hex_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      dpm;
    logic            hex;
    logic            lz;
    logic [3:0][6:0] s;   // expected segments, s[k] for digit k
  } vec_t;

  int checks = 0, errors = 0, n_upd = 0;

  // reference model state: cycles since reset release plus displayed/pending data
  int          tick;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pending;
  logic [6:0]  seg_rom [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tick = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pending = 1'b0;
  endtask

  task automatic step();
    int cnt, idx;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_upd, bnd;
    logic [15:0] sh;
    cnt   = tick % RD;
    idx   = (tick / RD) % D;
    e_an  = (cnt < DC) ? 4'b0000 : 4'(1 << idx);
    sh    = m_disp >> (4 * idx);
    e_seg = seg_rom[sh[3:0]];
    if (sh[3:0] >= 4'd10 && !hex_en) e_seg = '0;
    if (lz_blank && idx > 0 && sh == 16'h0000) e_seg = '0;
    e_dp  = m_dp[idx];
    if (e_an == 4'b0000) begin
      e_seg = '0;
      e_dp  = 1'b0;
    end
    bnd   = (cnt == RD - 1) && (idx == D - 1);
    e_upd = bnd && (m_pending || load);
    if (bnd) begin
      if (load) begin
        m_disp = value; m_dp = dp_mask;
      end else if (m_pending) begin
        m_disp = m_pend; m_dp = m_pdp;
      end
      m_pending = 1'b0;
    end else if (load) begin
      m_pend = value; m_pdp = dp_mask; m_pending = 1'b1;
    end
    tick++;
    @(posedge clk);
    #1;
    chk("scan{an,seg,dp,upd}", 32'({an, seg, dp, upd_done}), 32'({e_an, e_seg, e_dp, e_upd}));
    if (upd_done) n_upd++;
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 2 * D * RD && (tick % (D * RD)) != phase; i++) step();
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [6:0] got [4];
    logic       gdp [4];
    int         w;
    for (int k = 0; k < 4; k++) begin got[k] = 'x; gdp[k] = 1'bx; end
    hex_en = v.hex; lz_blank = v.lz; value = v.val; dp_mask = v.dpm; load = 1'b1;
    step();
    load = 1'b0;
    w = 0;
    while (!upd_done && w < 40) begin step(); w++; end
    chk($sformatf("vec%0d upd_done", n), 32'(upd_done), 32'(1));
    for (int c = 0; c < D * RD; c++) begin
      step();
      for (int k = 0; k < 4; k++)
        if (an == 4'(1 << k)) begin got[k] = seg; gdp[k] = dp; end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vec%0d seg digit%0d", n, k), 32'(got[k]), 32'(v.s[k]));
      chk($sformatf("vec%0d dp digit%0d", n, k), 32'(gdp[k]), 32'(v.dpm[k]));
    end
  endtask

  vec_t vecs [10];

  initial begin
    int n0;
    seg_rom = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h1234, 4'b0001, 1'b0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h00A0, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}};
    vecs[2] = '{16'h00A0, 4'b0000, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h00A0, 4'b0000, 1'b0, 1'b0, {7'h3F, 7'h3F, 7'h00, 7'h3F}};
    vecs[4] = '{16'hBCDE, 4'b1010, 1'b1, 1'b0, {7'h7C, 7'h39, 7'h5E, 7'h79}};
    vecs[5] = '{16'h0000, 4'b1111, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[6] = '{16'hF009, 4'b0000, 1'b1, 1'b1, {7'h71, 7'h3F, 7'h3F, 7'h6F}};
    vecs[7] = '{16'h0708, 4'b0010, 1'b0, 1'b1, {7'h00, 7'h07, 7'h3F, 7'h7F}};
    vecs[8] = '{16'h5600, 4'b0000, 1'b0, 1'b1, {7'h6D, 7'h7D, 7'h3F, 7'h3F}};
    vecs[9] = '{16'h2222, 4'b0000, 1'b0, 1'b0, {7'h5B, 7'h5B, 7'h5B, 7'h5B}};

    // reset state, then free-running scan of the zero value
    model_reset();
    #12;
    chk("reset outputs", 32'({an, seg, dp, upd_done}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();

    for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

    // two loads before one boundary: single upd_done, last value wins
    hex_en = 1'b0; lz_blank = 1'b0;
    align(1);
    n0 = n_upd;
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    step(); step();
    value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 2 * D * RD; i++) begin
      step();
      if (an != 4'b0000) chk("double load seg", 32'(seg), 32'(7'b1011011));
    end
    chk("double load upd count", 32'(n_upd - n0), 32'(1));

    // load on the boundary cycle: applied at once, upd_done the next cycle
    align(D * RD - 1);
    value = 16'h5678; dp_mask = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    chk("boundary load upd_done", 32'(upd_done), 32'(1));
    n0 = n_upd;
    for (int i = 0; i < 2 * D * RD; i++) begin
      step();
      chk("boundary dp only digit2", 32'(dp), 32'(an == 4'b0100));
    end
    chk("boundary load no extra upd", 32'(n_upd - n0), 32'(0));

    // asynchronous reset mid-slot with a pending load
    align(5);
    value = 16'h9999; load = 1'b1; step(); load = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'({an, seg, dp, upd_done}), 32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset held outputs", 32'({an, seg, dp, upd_done}), 32'(0));
    rst_n = 1'b1;
    n0 = n_upd;
    for (int i = 0; i < 3 * D * RD; i++) step();
    chk("no upd after reset", 32'(n_upd - n0), 32'(0));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      load    = ($urandom_range(0, 7) == 0);
      value   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        hex_en   = 1'($urandom);
        lz_blank = 1'($urandom);
      end
      step();
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
